// File: rtl/uart_byte_link_pkg.sv
// Shared constants and FSM state types for the 8N1 byte link.
package uart_byte_link_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int TX_GAP_CYCLES        = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE,
    TX_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud timer: counts up from 0 and ticks on the last cycle of a full bit,
// or of a half bit while half=1. start holds the count at 0.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == (half ? HALF_LAST : FULL_LAST));
    cnt_d = cnt_q + CW'(1);
    if (start || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_byte_link.sv
// 8N1 UART transceiver between the disk device controller and the serial pins.
//
// state    | meaning
// TX_IDLE  | waiting for dev_enable & dev_we
// TX_START | driving start bit (0)
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving stop bit (1)
// TX_DONE  | one cycle, dev_write_done=1
// TX_GAP   | two cycles; a held request relaunches at the end of the gap
// RX_IDLE  | waiting for a low on the synchronised line
// RX_START | half-bit wait, then confirm start bit (else glitch)
// RX_DATA  | sampling 8 data bits at bit centres
// RX_STOP  | sampling stop bit; store byte or flag framing error
module uart_byte_link
  import uart_byte_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dev_enable,
  input  logic       dev_we,
  input  logic [7:0] dev_data_out,
  output logic [7:0] dev_data_in,
  output logic       dev_read_done,
  output logic       dev_write_done,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [1:0] tx_gap_q, tx_gap_d;
  logic       uart_tx_q, uart_tx_d;
  logic       tx_tick, tx_req;

  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       rx_meta_q, rx_sync_q;
  logic       rx_tick, rx_byte_ok;

  logic [7:0] hold_q, hold_d;
  logic [7:0] data_in_q, data_in_d;
  logic       pending_q, pending_d;
  logic       read_done_q, read_done_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       deliver;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (!(tx_state_q inside {TX_START, TX_DATA, TX_STOP})),
    .half  (1'b0),
    .tick  (tx_tick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (rx_state_q == RX_IDLE),
    .half  (rx_state_q == RX_START),
    .tick  (rx_tick)
  );

  assign tx_req = dev_enable && dev_we;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_gap_d   = tx_gap_q;
    uart_tx_d  = uart_tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_req) begin
          tx_shift_d = dev_data_out;
          uart_tx_d  = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          uart_tx_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          uart_tx_d  = tx_shift_q[1];
          if (tx_bit_q == 3'd7) begin
            uart_tx_d  = 1'b1;
            tx_state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) tx_state_d = TX_DONE;
      end
      TX_DONE: begin
        tx_gap_d   = '0;
        tx_state_d = TX_GAP;
      end
      TX_GAP: begin
        tx_gap_d = tx_gap_q + 2'd1;
        // Request is only looked at once the gap has fully elapsed.
        if (tx_gap_q == 2'(TX_GAP_CYCLES - 1)) begin
          if (tx_req) begin
            tx_shift_d = dev_data_out;
            uart_tx_d  = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_byte_ok  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_byte_ok  = 1'b1;
          else           frame_err_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A delivery and a new byte in the same cycle: old byte goes out, new one stays pending.
  always_comb begin
    deliver     = pending_q && dev_enable && !dev_we;
    data_in_d   = data_in_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    read_done_d = deliver;
    if (deliver) begin
      data_in_d = hold_q;
      pending_d = 1'b0;
    end
    if (rx_byte_ok) begin
      hold_d    = rx_shift_q;
      pending_d = 1'b1;
      if (pending_q && !deliver) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_gap_q    <= '0;
      uart_tx_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      hold_q      <= '0;
      data_in_q   <= '0;
      pending_q   <= 1'b0;
      read_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_gap_q    <= tx_gap_d;
      uart_tx_q   <= uart_tx_d;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      hold_q      <= hold_d;
      data_in_q   <= data_in_d;
      pending_q   <= pending_d;
      read_done_q <= read_done_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign uart_tx        = uart_tx_q;
  assign dev_write_done = (tx_state_q == TX_DONE);
  assign dev_data_in    = data_in_q;
  assign dev_read_done  = read_done_q;
  assign rx_overrun     = overrun_q;
  assign rx_frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_byte_link.sv
// Bench for uart_byte_link at CLKS_PER_BIT=8: per-cycle behavioural model plus directed literal checks.
module tb_uart_byte_link;

  localparam int CPB    = 8;
  localparam int FRAME  = 10 * CPB;
  localparam int PERIOD = FRAME + 3;
  // Cycles from driving a start bit (at a negedge) to the posedge that stores the byte.
  localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_enable = 1'b0;
  logic       dev_we = 1'b0;
  logic [7:0] dev_data_out = 8'h00;
  logic [7:0] dev_data_in;
  logic       dev_read_done;
  logic       dev_write_done;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_seen = 0, wd_seen = 0, fe_seen = 0, wd_cyc = 0;

  always #5 clk = ~clk;

  uart_byte_link #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dev_enable     (dev_enable),
    .dev_we         (dev_we),
    .dev_data_out   (dev_data_out),
    .dev_data_in    (dev_data_in),
    .dev_read_done  (dev_read_done),
    .dev_write_done (dev_write_done),
    .uart_rx        (uart_rx),
    .uart_tx        (uart_tx),
    .rx_overrun     (rx_overrun),
    .rx_frame_err   (rx_frame_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model state
  typedef struct {
    int         due;
    logic [7:0] b;
    bit         ok;
  } rx_ev_t;
  rx_ev_t     rxq[$];
  rx_ev_t     ev;
  bit         m_busy, m_pend, m_overrun, m_rd, m_fe, m_deliver, m_new_pend;
  int         m_t;
  logic [9:0] m_frame;
  logic [7:0] m_hold, m_data_in;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_t = 0; m_frame = '1;
      m_pend = 0; m_overrun = 0; m_rd = 0; m_fe = 0;
      m_hold = 0; m_data_in = 0;
      rxq.delete();
    end else begin
      if (m_busy) begin
        m_t++;
        if (m_t == PERIOD) m_busy = 0;
      end
      if (!m_busy && dev_enable && dev_we) begin
        m_busy  = 1;
        m_t     = 0;
        m_frame = {1'b1, dev_data_out, 1'b0};
      end
      m_deliver  = m_pend && dev_enable && !dev_we;
      m_rd       = m_deliver;
      m_fe       = 0;
      m_new_pend = m_pend;
      if (m_deliver) begin
        m_data_in  = m_hold;
        m_new_pend = 0;
      end
      if (rxq.size() > 0 && rxq[0].due == cyc) begin
        ev = rxq.pop_front();
        if (ev.ok) begin
          if (m_pend && !m_deliver) m_overrun = 1;
          m_hold     = ev.b;
          m_new_pend = 1;
        end else begin
          m_fe = 1;
        end
      end
      m_pend = m_new_pend;
    end
    #1;
    chk("m_uart_tx", uart_tx, (m_busy && m_t < FRAME) ? int'(m_frame[m_t / CPB]) : 1);
    chk("m_write_done", dev_write_done, (m_busy && m_t == FRAME) ? 1 : 0);
    chk("m_data_in", dev_data_in, m_data_in);
    chk("m_read_done", dev_read_done, m_rd);
    chk("m_overrun", rx_overrun, m_overrun);
    chk("m_frame_err", rx_frame_err, m_fe);
    if (dev_read_done) rd_seen++;
    if (dev_write_done) begin wd_seen++; wd_cyc = cyc; end
    if (rx_frame_err) fe_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    rx_ev_t e;
    @(negedge clk);
    e.due = cyc + RX_LAT; e.b = b; e.ok = stop_ok;
    rxq.push_back(e);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int l_cyc, wd0, rd0, fe0, n;

    tick(3);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_data_in", dev_data_in, 0);
    chk("rst_overrun", rx_overrun, 0);
    rst_n = 1'b1;
    tick(3);

    // 1: single byte A5
    dev_enable = 1; dev_we = 1; dev_data_out = 8'hA5;
    wd0 = wd_seen; l_cyc = cyc + 1;
    tick(5);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick(CPB);
      chk($sformatf("a5_bit%0d", i), uart_tx, seq_a5[i]);
    end
    dev_we = 0;
    tick(10);
    chk("a5_done_count", wd_seen - wd0, 1);
    chk("a5_done_offset", wd_cyc - l_cyc, 80);

    // 1b: back-to-back bytes with data advanced after the first done
    wd0 = wd_seen;
    dev_we = 1; dev_data_out = 8'h0F;
    n = 0;
    while (!dev_write_done && n < 300) begin @(negedge clk); n++; end
    chk("b2b_first_done", dev_write_done, 1);
    dev_data_out = 8'hF0;
    tick(4);
    dev_we = 0;
    tick(2 * PERIOD);
    chk("b2b_done_count", wd_seen - wd0, 2);

    // 2: receive 3C
    rd0 = rd_seen;
    send_rx(8'h3C, 1);
    tick(10);
    chk("rx3c_pulses", rd_seen - rd0, 1);
    chk("rx3c_data", dev_data_in, 8'h3C);
    chk("rx3c_overrun", rx_overrun, 0);

    // 3: deferred delivery
    rd0 = rd_seen;
    dev_we = 1;
    send_rx(8'hFF, 1);
    tick(20);
    chk("defer_no_pulse", rd_seen - rd0, 0);
    dev_we = 0;
    @(negedge clk);
    chk("defer_pulse", dev_read_done, 1);
    chk("defer_data", dev_data_in, 8'hFF);
    tick(PERIOD);

    // 4: overrun, then framing error
    rd0 = rd_seen; fe0 = fe_seen;
    dev_we = 1;
    send_rx(8'h11, 1);
    tick(10);
    send_rx(8'h22, 1);
    tick(10);
    chk("ovr_flag", rx_overrun, 1);
    send_rx(8'h99, 0);
    tick(12);
    chk("fe_pulses", fe_seen - fe0, 1);
    chk("fe_no_delivery", rd_seen - rd0, 0);
    dev_we = 0;
    @(negedge clk);
    chk("ovr_data", dev_data_in, 8'h22);
    tick(5);
    chk("ovr_one_delivery", rd_seen - rd0, 1);
    chk("ovr_sticky", rx_overrun, 1);
    tick(PERIOD);

    // 5: glitch
    rd0 = rd_seen; fe0 = fe_seen;
    uart_rx = 0;
    tick(3);
    uart_rx = 1;
    tick(100);
    chk("glitch_no_read", rd_seen - rd0, 0);
    chk("glitch_no_fe", fe_seen - fe0, 0);

    // 6: reset mid-transmit, then a clean byte
    dev_we = 1; dev_data_out = 8'h55;
    tick(1);
    dev_we = 0;
    wd0 = wd_seen;
    tick(36);
    chk("rst_pre_tx_low", uart_tx, 0);
    #2 rst_n = 0;
    #1;
    chk("rst_async_tx", uart_tx, 1);
    chk("rst_async_data_in", dev_data_in, 0);
    chk("rst_async_overrun", rx_overrun, 0);
    chk("rst_async_wdone", dev_write_done, 0);
    tick(3);
    rst_n = 1;
    tick(100);
    chk("rst_no_done", wd_seen - wd0, 0);
    dev_we = 1; dev_data_out = 8'h5A;
    tick(1);
    dev_we = 0;
    tick(PERIOD + 5);
    chk("post_rst_done", wd_seen - wd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
